// File: rtl/uart_pkg.sv
// Shared UART definitions, used by both the TX and RX paths.
//   - uart_state_t      : TX frame sequencer states
//   - PAR_NONE/EVEN/ODD : parity mode encodings for the PARITY parameter
//   - UART_DATA_WIDTH   : default frame data width
//   - UART_DIV_WIDTH    : default baud divisor width
//   - parity_bit()      : turns the XOR of the data bits into the line parity bit
package uart_pkg;

    localparam int UART_DATA_WIDTH = 8;
    localparam int UART_DIV_WIDTH  = 16;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_START,
        ST_DATA,
        ST_PAR,
        ST_STOP
    } uart_state_t;

    // Even parity sends the XOR of the data bits, odd parity sends its inverse.
    function automatic logic parity_bit(input logic data_xor, input int mode);
        return (mode == PAR_ODD) ? ~data_xor : data_xor;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Loadable baud down-counter, shared by the UART TX and RX paths.
// Ports:
//   clk, rst      : clock and synchronous active-high reset
//   load          : reload the counter with div-1 (first cycle of a new bit)
//   div           : cycles per serial bit, already sanitised to be non-zero
//   bit_end       : counter is 0 -- this cycle is the last cycle of the bit
//   bit_end_next  : counter will be 0 next cycle; lets the owner register
//                   outputs that must line up with bit_end
module uart_baud_gen #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [DIV_WIDTH-1:0] div,
    output logic                 bit_end,
    output logic                 bit_end_next
);

    logic [DIV_WIDTH-1:0] cnt_reg;
    logic [DIV_WIDTH-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt_reg;
        if (load) begin
            cnt_next = (div == '0) ? '0 : div - DIV_WIDTH'(1);
        end else if (cnt_reg != '0) begin
            cnt_next = cnt_reg - DIV_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign bit_end      = (cnt_reg == '0);
    assign bit_end_next = (cnt_next == '0);

endmodule

// File: rtl/uart_tx_drain.sv
// UART transmitter that drains the byte FIFO: pops one byte whenever the FIFO
// has data (and enable is high), then sends start bit, DATA_WIDTH data bits
// LSB first, optional parity bit and one stop bit.
// Ports:
//   clk, rst        : clock and synchronous active-high reset
//   enable          : allows new frames to start; a running frame always completes
//   baud_div        : cycles per bit, sampled at the pop; 0 acts as 1
//   fifo_not_empty  : FIFO has at least one byte
//   fifo_dout       : FIFO read data (READ_LAT cycles after fifo_rd)
//   fifo_rd         : one-cycle pop strobe, only ever raised while idle
//   tx              : serial line, idles high
//   busy            : sequencer is not idle
//   frame_done      : one-cycle pulse on the last cycle of the stop bit
// All outputs come straight from flops: each is computed from next-state
// values so it lines up with the state it belongs to.
module uart_tx_drain
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH,
    parameter int DIV_WIDTH  = UART_DIV_WIDTH,
    parameter int PARITY     = PAR_NONE,
    parameter int READ_LAT   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [DIV_WIDTH-1:0]  baud_div,
    input  logic                  fifo_not_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_rd,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    uart_state_t           state_reg,  state_next;
    logic [DATA_WIDTH-1:0] shift_reg,  shift_next;
    logic                  par_reg,    par_next;
    logic [IDX_W-1:0]      bit_idx_reg, bit_idx_next;
    logic [DIV_WIDTH-1:0]  div_reg,    div_next;
    logic                  fifo_rd_reg, fifo_rd_next;
    logic                  tx_reg,     tx_next;
    logic                  busy_reg,   busy_next;
    logic                  frame_done_reg, frame_done_next;

    logic                  load;
    logic                  bit_end;
    logic                  bit_end_next;
    logic [DIV_WIDTH-1:0]  div_eff;

    assign div_eff = (baud_div == '0) ? DIV_WIDTH'(1) : baud_div;

    // The counter is fed div_next so a bit loaded on the same edge that the
    // divisor is latched (READ_LAT = 0) already uses the new divisor.
    uart_baud_gen #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_baud_gen (
        .clk          (clk),
        .rst          (rst),
        .load         (load),
        .div          (div_next),
        .bit_end      (bit_end),
        .bit_end_next (bit_end_next)
    );

    // Sequencer next-state logic.
    always_comb begin
        state_next   = state_reg;
        shift_next   = shift_reg;
        par_next     = par_reg;
        bit_idx_next = bit_idx_reg;
        div_next     = div_reg;
        load         = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                // fifo_rd_reg high means this is the pop cycle.
                if (fifo_rd_reg) begin
                    div_next = div_eff;
                    if (READ_LAT == 0) begin
                        shift_next = fifo_dout;
                        par_next   = ^fifo_dout;
                        state_next = ST_START;
                        load       = 1'b1;
                    end else begin
                        state_next = ST_FETCH;
                    end
                end
            end
            ST_FETCH: begin
                shift_next = fifo_dout;
                par_next   = ^fifo_dout;
                state_next = ST_START;
                load       = 1'b1;
            end
            ST_START: begin
                if (bit_end) begin
                    state_next   = ST_DATA;
                    bit_idx_next = '0;
                    load         = 1'b1;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    load = 1'b1;
                    if (bit_idx_reg == IDX_W'(DATA_WIDTH - 1)) begin
                        state_next = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
                    end else begin
                        shift_next   = shift_reg >> 1;
                        bit_idx_next = bit_idx_reg + 1'b1;
                    end
                end
            end
            ST_PAR: begin
                if (bit_end) begin
                    state_next = ST_STOP;
                    load       = 1'b1;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Output values for the coming cycle, derived from the next state.
    always_comb begin
        tx_next = 1'b1;
        case (state_next)
            ST_START: tx_next = 1'b0;
            ST_DATA:  tx_next = shift_next[0];
            ST_PAR:   tx_next = parity_bit(par_next, PARITY);
            default:  tx_next = 1'b1;
        endcase

        // The pop is decided one cycle ahead, so it can be raised in the
        // very first idle cycle after frame_done. Once the sequencer leaves
        // IDLE the strobe is forced low, which limits it to one pop per frame.
        fifo_rd_next    = (state_next == ST_IDLE) && enable && fifo_not_empty;
        busy_next       = (state_next != ST_IDLE);
        frame_done_next = (state_next == ST_STOP) && bit_end_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            shift_reg      <= '0;
            par_reg        <= 1'b0;
            bit_idx_reg    <= '0;
            div_reg        <= DIV_WIDTH'(1);
            fifo_rd_reg    <= 1'b0;
            tx_reg         <= 1'b1;
            busy_reg       <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            shift_reg      <= shift_next;
            par_reg        <= par_next;
            bit_idx_reg    <= bit_idx_next;
            div_reg        <= div_next;
            fifo_rd_reg    <= fifo_rd_next;
            tx_reg         <= tx_next;
            busy_reg       <= busy_next;
            frame_done_reg <= frame_done_next;
        end
    end

    assign fifo_rd    = fifo_rd_reg;
    assign tx         = tx_reg;
    assign busy       = busy_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_uart_tx_drain.sv
module tb_uart_tx_drain;
    import uart_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] baud_div = 16'd4;
    logic [1:0]  sel = 2'd0;

    // Simple FIFO model shared by all instances; only the selected one pops.
    logic [7:0] mem [0:255];
    logic [7:0] push_cnt = 8'd0;
    logic [7:0] pop_cnt = 8'd0;
    logic [7:0] dout_reg = 8'd0;
    int         rd_pulses = 0;
    logic       fne;
    logic [7:0] fifo_dout;

    logic [3:0] tx_v, busy_v, rd_v, done_v, en_v;
    logic       tx_s, busy_s, rd_s, done_s;

    int passed = 0;
    int total = 0;

    assign fne       = (push_cnt != pop_cnt);
    assign fifo_dout = (sel == 2'd3) ? mem[pop_cnt] : dout_reg;
    assign tx_s      = tx_v[sel];
    assign busy_s    = busy_v[sel];
    assign rd_s      = rd_v[sel];
    assign done_s    = done_v[sel];

    // 0: no parity RL1, 1: even RL1, 2: odd RL1, 3: no parity RL0
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_dut
            assign en_v[gi] = enable && (sel == 2'(gi));
            uart_tx_drain #(
                .DATA_WIDTH (8),
                .DIV_WIDTH  (16),
                .PARITY     ((gi == 1) ? PAR_EVEN : ((gi == 2) ? PAR_ODD : PAR_NONE)),
                .READ_LAT   ((gi == 3) ? 0 : 1)
            ) u_dut (
                .clk            (clk),
                .rst            (rst),
                .enable         (en_v[gi]),
                .baud_div       (baud_div),
                .fifo_not_empty (fne),
                .fifo_dout      (fifo_dout),
                .fifo_rd        (rd_v[gi]),
                .tx             (tx_v[gi]),
                .busy           (busy_v[gi]),
                .frame_done     (done_v[gi])
            );
        end
    endgenerate

    always @(posedge clk) begin
        if (rd_s === 1'b1) begin
            rd_pulses <= rd_pulses + 1;
            if (fne) begin
                dout_reg <= mem[pop_cnt];
                pop_cnt  <= pop_cnt + 8'd1;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push(input logic [7:0] b);
        mem[push_cnt] = b;
        push_cnt = push_cnt + 8'd1;
    endtask

    // Step negedges until tx goes low (bounded); report delay and pop cycle.
    task automatic wait_start(output int n, output int rd_at);
        n = 0;
        rd_at = -1;
        do begin
            @(negedge clk);
            n++;
            if (rd_s === 1'b1 && rd_at < 0) rd_at = n;
        end while (tx_s !== 1'b0 && n < 200);
    endtask

    // Checks a whole frame cycle by cycle; ends on the frame_done negedge.
    // act 1: switch baud_div to 5 at act_cyc; act 2: drop enable at act_cyc.
    task automatic expect_frame(input string tag, input logic [7:0] data, input int div,
                                input int par_mode, input int exp_n,
                                input int act_cyc, input int act);
        int n;
        int rd_at;
        int nb;
        int last;
        logic [11:0] bits;
        wait_start(n, rd_at);
        chk({tag, " start_delay"}, 32'(n), 32'(exp_n));
        chk({tag, " rd_cycle"}, 32'(rd_at), 32'd1);
        bits = '0;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1 + i] = data[i];
        nb = 9;
        if (par_mode != 0) begin
            bits[nb] = (par_mode == 1) ? (^data) : ~(^data);
            nb++;
        end
        bits[nb] = 1'b1;
        nb++;
        last = nb * div - 1;
        for (int c = 0; c <= last; c++) begin
            if (c > 0) @(negedge clk);
            if (c == act_cyc && act == 1) baud_div = 16'd5;
            if (c == act_cyc && act == 2) enable = 1'b0;
            chk($sformatf("%s tx c%0d", tag, c), 32'(tx_s), 32'(bits[c / div]));
            chk($sformatf("%s busy c%0d", tag, c), 32'(busy_s), 32'd1);
            chk($sformatf("%s done c%0d", tag, c), 32'(done_s), 32'(c == last));
        end
        $display("frame %s data=%02h div=%0d bits=%0d delay=%0d", tag, data, div, nb, n);
    endtask

    task automatic quiet(input string tag, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            chk($sformatf("%s tx c%0d", tag, c), 32'(tx_s), 32'd1);
            chk($sformatf("%s busy c%0d", tag, c), 32'(busy_s), 32'd0);
            chk($sformatf("%s rd c%0d", tag, c), 32'(rd_s), 32'd0);
        end
    endtask

    initial begin
        int r0;
        int n;
        int rd_at;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset tx", 32'(tx_s), 32'd1);
        chk("reset busy", 32'(busy_s), 32'd0);
        chk("reset rd", 32'(rd_s), 32'd0);
        chk("reset done", 32'(done_s), 32'd0);
        $display("reset checked");
        rst = 1'b0;
        @(negedge clk);

        // Single byte 0x55, div 4
        push(8'h55);
        r0 = rd_pulses;
        enable = 1'b1;
        expect_frame("single", 8'h55, 4, 0, 3, -1, 0);
        quiet("single idle", 5);
        chk("single pops", 32'(rd_pulses - r0), 32'd1);

        // Back-to-back 0xA3, 0x0F, div 2
        baud_div = 16'd2;
        push(8'hA3);
        push(8'h0F);
        r0 = rd_pulses;
        expect_frame("b2b1", 8'hA3, 2, 0, 3, -1, 0);
        expect_frame("b2b2", 8'h0F, 2, 0, 3, -1, 0);
        quiet("b2b idle", 5);
        chk("b2b pops", 32'(rd_pulses - r0), 32'd2);

        // Parity even / odd with 0x07, div 3
        sel = 2'd1;
        baud_div = 16'd3;
        push(8'h07);
        expect_frame("even", 8'h07, 3, 1, 3, -1, 0);
        quiet("even idle", 3);
        sel = 2'd2;
        push(8'h07);
        expect_frame("odd", 8'h07, 3, 2, 3, -1, 0);
        quiet("odd idle", 3);

        // READ_LAT = 0: tx falls one edge after the pop cycle
        sel = 2'd3;
        baud_div = 16'd2;
        push(8'h3C);
        expect_frame("rl0", 8'h3C, 2, 0, 2, -1, 0);
        quiet("rl0 idle", 3);

        // baud_div = 0 acts as 1
        sel = 2'd0;
        baud_div = 16'd0;
        push(8'h81);
        expect_frame("div0", 8'h81, 1, 0, 3, -1, 0);
        quiet("div0 idle", 3);

        // Divisor change mid-frame: 3 kept, next frame uses 5
        baud_div = 16'd3;
        push(8'hC6);
        push(8'h5A);
        expect_frame("divchg1", 8'hC6, 3, 0, 3, 5, 1);
        expect_frame("divchg2", 8'h5A, 5, 0, 3, -1, 0);
        quiet("divchg idle", 3);

        // enable low with data waiting: nothing happens
        enable = 1'b0;
        baud_div = 16'd3;
        push(8'h99);
        r0 = rd_pulses;
        quiet("disabled", 20);
        chk("disabled pops", 32'(rd_pulses - r0), 32'd0);

        // enable dropped mid-frame: frame completes, no further pop
        push(8'h42);
        enable = 1'b1;
        expect_frame("endrop", 8'h99, 3, 0, 3, 4, 2);
        quiet("endrop idle", 20);
        chk("endrop pops", 32'(rd_pulses - r0), 32'd1);
        push_cnt = pop_cnt;

        // Reset during DATA bit 3 of 0xB4 (bit 3 is 0), then 0x2D goes normally
        baud_div = 16'd2;
        push(8'hB4);
        push(8'h2D);
        r0 = rd_pulses;
        enable = 1'b1;
        wait_start(n, rd_at);
        chk("rstmid start_delay", 32'(n), 32'd3);
        repeat (8) @(negedge clk);
        chk("rstmid bit3 tx", 32'(tx_s), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid tx", 32'(tx_s), 32'd1);
        chk("rstmid busy", 32'(busy_s), 32'd0);
        chk("rstmid rd", 32'(rd_s), 32'd0);
        chk("rstmid done", 32'(done_s), 32'd0);
        $display("reset mid-frame checked");
        @(negedge clk);
        rst = 1'b0;
        expect_frame("afterrst", 8'h2D, 2, 0, 3, -1, 0);
        quiet("afterrst idle", 5);
        chk("rstmid pops", 32'(rd_pulses - r0), 32'd2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
